decode_issue_queue: RTL

Elastic FIFO between the ID stage and the issue stage, single issue port. Holds decoded scoreboard entries with their raw instruction word and control-flow flag. Decouples decode throughput from issue stalls such as a full scoreboard, busy FUs or CVXIF back-pressure. The issue stage consumes the head via a valid/ack handshake and also receives the last entry it accepted, on its `decoded_instr_i_prev` input.

---
 rtl/decode_issue_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/decode_issue_queue.sv
// Elastic decode-to-issue FIFO with a single issue port and last-popped-entry output.
// Optional same-cycle bypass of an empty queue: define DECODE_ISSUE_QUEUE_BYPASS_EN.
module decode_issue_queue #(
    parameter int unsigned NrIssuePorts       = 1,
    parameter type         scoreboard_entry_t = logic,
    parameter int unsigned DEPTH              = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  scoreboard_entry_t       decoded_instr_i,
    input  logic [31:0]             orig_instr_i,
    input  logic                    is_ctrl_flow_i,
    input  logic                    decoded_instr_valid_i,
    output logic                    decoded_instr_ack_o,
    output scoreboard_entry_t       issue_instr_o,
    output logic [31:0]             orig_instr_o,
    output logic                    is_ctrl_flow_o,
    output logic                    issue_instr_valid_o,
    input  logic                    issue_ack_i,
    output scoreboard_entry_t       issue_instr_prev_o,
    output logic                    ctrl_flow_in_queue_o,
    output logic [$clog2(DEPTH):0]  usage_o,
    output logic                    full_o
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned UsageW = PtrW + 1;

    if (NrIssuePorts != 1) begin : gen_bad_cfg
        $error("decode_issue_queue supports a single issue port only");
    end

    scoreboard_entry_t entry_mem [DEPTH];
    logic [31:0]       orig_mem  [DEPTH];
    logic [DEPTH-1:0]  ctrl_mem;

    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [UsageW-1:0] usage_q, usage_d, ctrl_cnt_q, ctrl_cnt_d;
    scoreboard_entry_t prev_q, prev_d;

    logic push, pop, bypass, wr_en, rd_adv, ctrl_inc, ctrl_dec;

    assign full_o               = (usage_q == UsageW'(DEPTH));
    assign usage_o              = usage_q;
    assign ctrl_flow_in_queue_o = (ctrl_cnt_q != '0);
    assign issue_instr_prev_o   = prev_q;

    // Upstream accept never looks at issue_ack_i: no issue-to-ID combinational path.
    assign decoded_instr_ack_o = !full_o && !flush_i;
    assign push                = decoded_instr_valid_i && decoded_instr_ack_o;

`ifdef DECODE_ISSUE_QUEUE_BYPASS_EN
    assign bypass = (usage_q == '0) && decoded_instr_valid_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign issue_instr_valid_o = ((usage_q != '0) || bypass) && !flush_i;
    assign pop                 = issue_instr_valid_o && issue_ack_i;

    // A bypassed entry that is acked immediately never occupies a slot.
    assign wr_en    = push && !(bypass && issue_ack_i);
    assign rd_adv   = pop && !bypass;
    assign ctrl_inc = wr_en && is_ctrl_flow_i;
    assign ctrl_dec = rd_adv && ctrl_mem[rd_ptr_q];

    always_comb begin
        if (bypass) begin
            issue_instr_o  = decoded_instr_i;
            orig_instr_o   = orig_instr_i;
            is_ctrl_flow_o = is_ctrl_flow_i;
        end else begin
            issue_instr_o  = entry_mem[rd_ptr_q];
            orig_instr_o   = orig_mem[rd_ptr_q];
            is_ctrl_flow_o = ctrl_mem[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        usage_d    = usage_q;
        ctrl_cnt_d = ctrl_cnt_q;
        prev_d     = prev_q;
        if (flush_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            usage_d    = '0;
            ctrl_cnt_d = '0;
            prev_d     = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (pop) begin
                prev_d = issue_instr_o;
            end
            case ({wr_en, rd_adv})
                2'b10:   usage_d = usage_q + UsageW'(1);
                2'b01:   usage_d = usage_q - UsageW'(1);
                default: usage_d = usage_q;
            endcase
            case ({ctrl_inc, ctrl_dec})
                2'b10:   ctrl_cnt_d = ctrl_cnt_q + UsageW'(1);
                2'b01:   ctrl_cnt_d = ctrl_cnt_q - UsageW'(1);
                default: ctrl_cnt_d = ctrl_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            usage_q    <= '0;
            ctrl_cnt_q <= '0;
            prev_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            usage_q    <= usage_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            prev_q     <= prev_d;
        end
    end

    // Payload storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            entry_mem[wr_ptr_q] <= decoded_instr_i;
            orig_mem[wr_ptr_q]  <= orig_instr_i;
            ctrl_mem[wr_ptr_q]  <= is_ctrl_flow_i;
        end
    end

endmodule
